// File: rtl/cc1200_spi_pkg.sv
// Shared constants and state encoding for the CC1200-style SPI register slave.
package cc1200_spi_pkg;
  localparam int BYTE_W     = 8;
  localparam int HDR_RW     = 7;
  localparam int HDR_BURST  = 6;
  localparam int HDR_ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } spi_state_e;
endpackage

// File: rtl/cc1200_sync.sv
// N-stage synchronizer for one asynchronous input; resets to a chosen idle level.
module cc1200_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] ff_q;

  if (N > 1) begin : g_multi
    always_ff @(posedge clk or posedge rst) begin
      if (rst) ff_q <= {N{RST_VAL}};
      else     ff_q <= {ff_q[N-2:0], d_i};
    end
  end else begin : g_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) ff_q <= RST_VAL;
      else     ff_q <= d_i;
    end
  end

  assign q_o = ff_q[N-1];
endmodule

// File: rtl/cc1200_spi_slave.sv
// SPI mode-0 register slave: header byte (R/W, burst, address) then data bytes,
// with status returned during the header. All logic runs on clk; SPI pins are synchronized.
module cc1200_spi_slave
  import cc1200_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              CS_n,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic [7:0]        status_in,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);
  localparam int BIT_W = $clog2(BYTE_W);
  localparam int FLUSH = SYNC_STAGES + 1;
  localparam int FL_W  = $clog2(FLUSH + 1);

  logic sclk_s, mosi_s, csn_s;

  cc1200_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(SCLK), .q_o(sclk_s));
  cc1200_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(MOSI), .q_o(mosi_s));
  cc1200_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst(rst), .d_i(CS_n), .q_o(csn_s));

  spi_state_e         state_q;
  logic               sclk_prev_q, csn_prev_q, armed_q;
  logic [FL_W-1:0]    flush_q;
  logic [BIT_W-1:0]   bitcnt_q;
  logic [BYTE_W-2:0]  rx_q;
  logic [BYTE_W-1:0]  tx_q, last_rd_q, wdata_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               miso_q, oe_q, busy_q, we_q, re_q, load_q;
  logic               rw_q, burst_q, first_q;

  logic              sclk_rise, sclk_fall, csn_fall, csn_rise, byte_done, flushed;
  logic [BYTE_W-1:0] rx_d;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign rx_d      = {rx_q, mosi_s};
  assign byte_done = sclk_rise && (bitcnt_q == BIT_W'(BYTE_W - 1));
  assign flushed   = (flush_q == FL_W'(FLUSH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
      flush_q     <= '0;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '1;
      last_rd_q   <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      load_q      <= 1'b0;
      rw_q        <= 1'b0;
      burst_q     <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      if (!flushed) flush_q <= flush_q + FL_W'(1);
      // A start is only accepted after CS_n has been seen high with real pin data.
      if (flushed && csn_s) armed_q <= 1'b1;
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      load_q <= re_q;
      if (load_q) begin
        tx_q      <= reg_rdata;
        last_rd_q <= reg_rdata;
      end
      if (we_q && burst_q) addr_q <= addr_q + ADDR_W'(1);

      if (csn_rise) begin
        state_q  <= ST_IDLE;
        bitcnt_q <= '0;
        miso_q   <= 1'b1;
        oe_q     <= 1'b0;
        busy_q   <= 1'b0;
        load_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csn_fall && armed_q) begin
              state_q  <= ST_HEADER;
              bitcnt_q <= '0;
              tx_q     <= status_in;
              miso_q   <= status_in[BYTE_W-1];
              oe_q     <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          default: begin
            if (sclk_rise) begin
              rx_q     <= rx_d[BYTE_W-2:0];
              bitcnt_q <= bitcnt_q + BIT_W'(1);
              if (byte_done) begin
                if (state_q == ST_HEADER) begin
                  state_q <= ST_DATA;
                  rw_q    <= rx_d[HDR_RW];
                  burst_q <= rx_d[HDR_BURST];
                  addr_q  <= ADDR_W'(rx_d[HDR_ADDR_W-1:0]);
                  first_q <= 1'b1;
                  if (rx_d[HDR_RW]) re_q <= 1'b1;
                  else              tx_q <= status_in;
                end else begin
                  first_q <= 1'b0;
                  if (first_q || burst_q) begin
                    if (rw_q) begin
                      if (burst_q) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        re_q   <= 1'b1;
                      end else begin
                        tx_q <= last_rd_q;
                      end
                    end else begin
                      wdata_q <= rx_d;
                      we_q    <= 1'b1;
                      tx_q    <= status_in;
                    end
                  end else begin
                    tx_q <= rw_q ? last_rd_q : status_in;
                  end
                end
              end
            end else if (sclk_fall) begin
              // Fall after a byte boundary presents the freshly loaded byte's MSB.
              if (bitcnt_q == '0) begin
                miso_q <= tx_q[BYTE_W-1];
              end else begin
                miso_q <= tx_q[BYTE_W-2];
                tx_q   <= {tx_q[BYTE_W-2:0], 1'b1};
              end
            end
          end
        endcase
      end
    end
  end

  assign MISO      = miso_q;
  assign MISO_oe   = oe_q;
  assign busy      = busy_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
endmodule

// File: tb/tb_cc1200_spi_slave.sv
// Directed bench for cc1200_spi_slave: SPI master tasks, register-file model, strobe monitor.
module tb_cc1200_spi_slave;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0, rst = 1'b1;
  logic       SCLK = 1'b0, MOSI = 1'b0, CS_n = 1'b1;
  logic       MISO, MISO_oe, reg_we, reg_re, busy;
  logic [7:0] status_in = 8'h0F;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [7:0] mem [0:63];
  logic [5:0] we_addr[$];
  logic [7:0] we_data[$];
  logic [5:0] re_addr[$];

  cc1200_spi_slave #(.SYNC_STAGES(SS), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
    .MISO(MISO), .MISO_oe(MISO_oe), .status_in(status_in),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  always @(negedge clk) begin
    if (reg_we) begin we_addr.push_back(reg_addr); we_data.push_back(reg_wdata); end
    if (reg_re) re_addr.push_back(reg_addr);
    if (reg_we && reg_re) viol++;
    if ((reg_we || reg_re) && !busy) viol++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    we_addr.delete(); we_data.delete(); re_addr.delete();
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      MOSI = tx[i];
      wait_clk(HALF);
      rx[i] = MISO;
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic cs_begin();
    CS_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    CS_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic test_reset();
    checks++; if (MISO !== 1'b1)    begin errors++; $display("FAIL rst_miso got %b exp 1", MISO); end
    checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", MISO_oe); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (reg_we !== 1'b0 || reg_re !== 1'b0)
      begin errors++; $display("FAIL rst_strobes got we=%b re=%b exp 0 0", reg_we, reg_re); end
    checks++; if (reg_addr !== 6'h00 || reg_wdata !== 8'h00)
      begin errors++; $display("FAIL rst_regs got addr=%h wdata=%h exp 00 00", reg_addr, reg_wdata); end
  endtask

  task automatic test_single_write();
    logic [7:0] rx;
    clear_log();
    cs_begin();
    checks++; if (busy !== 1'b1 || MISO_oe !== 1'b1 || MISO !== 1'b0)
      begin errors++; $display("FAIL wr_start got busy=%b oe=%b miso=%b exp 1 1 0", busy, MISO_oe, MISO); end
    spi_byte(8'h0A, rx);
    checks++; if (rx !== 8'h0F) begin errors++; $display("FAIL wr_status got %h exp 0f", rx); end
    spi_byte(8'h5C, rx);
    cs_end();
    checks++; if (we_addr.size() !== 1 || re_addr.size() !== 0)
      begin errors++; $display("FAIL wr_count got we=%0d re=%0d exp 1 0", we_addr.size(), re_addr.size()); end
    else begin
      checks++; if (we_addr[0] !== 6'h0A || we_data[0] !== 8'h5C)
        begin errors++; $display("FAIL wr_data got %h/%h exp 0a/5c", we_addr[0], we_data[0]); end
    end
    checks++; if (busy !== 1'b0 || MISO_oe !== 1'b0 || MISO !== 1'b1)
      begin errors++; $display("FAIL wr_end got busy=%b oe=%b miso=%b exp 0 0 1", busy, MISO_oe, MISO); end
  endtask

  task automatic test_single_read();
    logic [7:0] rx;
    clear_log();
    cs_begin();
    spi_byte(8'h8A, rx);
    checks++; if (rx !== 8'h0F) begin errors++; $display("FAIL rd_status got %h exp 0f", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL rd_data got %h exp a5", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL rd_repeat got %h exp a5", rx); end
    cs_end();
    checks++; if (re_addr.size() !== 1 || we_addr.size() !== 0)
      begin errors++; $display("FAIL rd_count got re=%0d we=%0d exp 1 0", re_addr.size(), we_addr.size()); end
    else begin
      checks++; if (re_addr[0] !== 6'h0A) begin errors++; $display("FAIL rd_addr got %h exp 0a", re_addr[0]); end
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] rx;
    clear_log();
    cs_begin();
    spi_byte(8'h7E, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    spi_byte(8'h33, rx);
    checks++; if (rx !== 8'h0F) begin errors++; $display("FAIL bw_miso got %h exp 0f", rx); end
    cs_end();
    checks++; if (we_addr.size() !== 3)
      begin errors++; $display("FAIL bw_count got %0d exp 3", we_addr.size()); end
    else begin
      checks++; if (we_addr[0] !== 6'h3E || we_data[0] !== 8'h11)
        begin errors++; $display("FAIL bw_0 got %h/%h exp 3e/11", we_addr[0], we_data[0]); end
      checks++; if (we_addr[1] !== 6'h3F || we_data[1] !== 8'h22)
        begin errors++; $display("FAIL bw_1 got %h/%h exp 3f/22", we_addr[1], we_data[1]); end
      checks++; if (we_addr[2] !== 6'h00 || we_data[2] !== 8'h33)
        begin errors++; $display("FAIL bw_2 got %h/%h exp 00/33", we_addr[2], we_data[2]); end
    end
  endtask

  task automatic test_burst_read();
    logic [7:0] rx;
    clear_log();
    cs_begin();
    spi_byte(8'hFE, rx);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL br_0 got %h exp 3c", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hC3) begin errors++; $display("FAIL br_1 got %h exp c3", rx); end
    cs_end();
    checks++; if (re_addr.size() !== 3)
      begin errors++; $display("FAIL br_count got %0d exp 3", re_addr.size()); end
    else begin
      checks++; if (re_addr[0] !== 6'h3E || re_addr[1] !== 6'h3F || re_addr[2] !== 6'h00)
        begin errors++; $display("FAIL br_addr got %h %h %h exp 3e 3f 00", re_addr[0], re_addr[1], re_addr[2]); end
    end
  endtask

  task automatic test_nonburst_extra();
    logic [7:0] rx;
    clear_log();
    cs_begin();
    spi_byte(8'h05, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h02, rx);
    checks++; if (rx !== 8'h0F) begin errors++; $display("FAIL nb_miso got %h exp 0f", rx); end
    cs_end();
    checks++; if (we_addr.size() !== 1)
      begin errors++; $display("FAIL nb_count got %0d exp 1", we_addr.size()); end
    else begin
      checks++; if (we_addr[0] !== 6'h05 || we_data[0] !== 8'h01)
        begin errors++; $display("FAIL nb_data got %h/%h exp 05/01", we_addr[0], we_data[0]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic [7:0] pat;
    clear_log();
    pat = 8'hE7;
    cs_begin();
    spi_byte(8'h0A, rx);
    for (int i = 7; i >= 3; i--) begin
      MOSI = pat[i];
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
    wait_clk(HALF);
    CS_n = 1'b1;
    wait_clk(SS + 2);
    checks++; if (busy !== 1'b0 || MISO_oe !== 1'b0 || MISO !== 1'b1)
      begin errors++; $display("FAIL ab_idle got busy=%b oe=%b miso=%b exp 0 0 1", busy, MISO_oe, MISO); end
    wait_clk(2 * HALF);
    checks++; if (we_addr.size() !== 0) begin errors++; $display("FAIL ab_nowe got %0d exp 0", we_addr.size()); end
    cs_begin();
    spi_byte(8'h01, rx);
    spi_byte(8'h77, rx);
    cs_end();
    checks++; if (we_addr.size() !== 1)
      begin errors++; $display("FAIL ab_recover_count got %0d exp 1", we_addr.size()); end
    else begin
      checks++; if (we_addr[0] !== 6'h01 || we_data[0] !== 8'h77)
        begin errors++; $display("FAIL ab_recover got %h/%h exp 01/77", we_addr[0], we_data[0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'hC0, rx);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h96) begin errors++; $display("FAIL rm_pre got %h exp 96", rx); end
    for (int i = 0; i < 3; i++) begin
      wait_clk(HALF); SCLK = 1'b1; wait_clk(HALF); SCLK = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || MISO_oe !== 1'b0 || MISO !== 1'b1 || reg_addr !== 6'h00 ||
                  reg_wdata !== 8'h00 || reg_we !== 1'b0 || reg_re !== 1'b0)
      begin errors++; $display("FAIL rm_async got busy=%b oe=%b miso=%b addr=%h wd=%h exp 0 0 1 00 00",
                               busy, MISO_oe, MISO, reg_addr, reg_wdata); end
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    clear_log();
    spi_byte(8'h8A, rx);
    spi_byte(8'h33, rx);
    checks++; if (busy !== 1'b0 || MISO_oe !== 1'b0)
      begin errors++; $display("FAIL rm_stay_idle got busy=%b oe=%b exp 0 0", busy, MISO_oe); end
    checks++; if (we_addr.size() !== 0 || re_addr.size() !== 0)
      begin errors++; $display("FAIL rm_nostrobe got we=%0d re=%0d exp 0 0", we_addr.size(), re_addr.size()); end
    CS_n = 1'b1;
    wait_clk(2 * HALF);
    cs_begin();
    spi_byte(8'h02, rx);
    checks++; if (rx !== 8'h0F) begin errors++; $display("FAIL rm_hdr got %h exp 0f", rx); end
    spi_byte(8'h9A, rx);
    cs_end();
    checks++; if (we_addr.size() !== 1)
      begin errors++; $display("FAIL rm_count got %0d exp 1", we_addr.size()); end
    else begin
      checks++; if (we_addr[0] !== 6'h02 || we_data[0] !== 8'h9A)
        begin errors++; $display("FAIL rm_data got %h/%h exp 02/9a", we_addr[0], we_data[0]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h55;
    mem[6'h0A] = 8'hA5;
    mem[6'h3E] = 8'h3C;
    mem[6'h3F] = 8'hC3;
    mem[6'h00] = 8'h96;
    rst = 1'b1;
    wait_clk(3);
    test_reset();
    rst = 1'b0;
    wait_clk(6);
    test_single_write();
    test_single_read();
    test_burst_wrap();
    test_burst_read();
    test_nonburst_extra();
    test_abort();
    test_reset_mid();
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules got %0d violations exp 0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
